// File: rtl/sram_pkg.sv
// sram_pkg: shared types for the dual-port byte-enable SRAM.
// Revision: 1.0
`default_nettype none

package sram_pkg;

  typedef enum logic {
    WRITE_FIRST = 1'b0,
    READ_FIRST  = 1'b1
  } rdw_mode_e;

  typedef enum logic {
    CLEAR = 1'b0,
    DONE  = 1'b1
  } sram_init_e;

  localparam int BYTE_W = 8;

endpackage

`default_nettype wire

// File: rtl/sram_init_ctrl.sv
// sram_init_ctrl: post-reset sequencer that zeroes every word, then raises ready.
// Revision: 1.0
`default_nettype none

module sram_init_ctrl
  import sram_pkg::*;
#(
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  clr_we,
  output logic [ADDR_WIDTH-1:0] clr_addr,
  output logic                  ready
);

  sram_init_e            state_q;
  logic [ADDR_WIDTH-1:0] ptr_q;
  logic                  ready_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CLEAR;
      ptr_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      case (state_q)
        CLEAR: begin
          ptr_q <= ptr_q + ADDR_WIDTH'(1);
          // Last word is written on this edge, so ready appears after exactly DEPTH edges.
          if (ptr_q == '1) begin
            state_q <= DONE;
            ready_q <= 1'b1;
          end
        end
        DONE: begin
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= CLEAR;
          ptr_q   <= '0;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign clr_we   = (state_q == CLEAR);
  assign clr_addr = ptr_q;
  assign ready    = ready_q;

endmodule

`default_nettype wire

// File: rtl/sram_dp_be.sv
// sram_dp_be: 1W/1R synchronous SRAM with byte enables, 1/2-cycle read and RDW policy.
// Revision: 1.0
`default_nettype none

module sram_dp_be
  import sram_pkg::*;
#(
  parameter int        ADDR_WIDTH   = 4,
  parameter int        DATA_WIDTH   = 32,
  parameter int        READ_LATENCY = 1,
  parameter rdw_mode_e RDW_MODE     = WRITE_FIRST
) (
  input  logic                    clk,
  input  logic                    rst_n,
  output logic                    ready,
  input  logic                    wr_en,
  input  logic [ADDR_WIDTH-1:0]   wr_addr,
  input  logic [DATA_WIDTH/8-1:0] wr_be,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic                    rd_en,
  input  logic [ADDR_WIDTH-1:0]   rd_addr,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    rd_valid
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int NB    = DATA_WIDTH / BYTE_W;

  if (DATA_WIDTH % BYTE_W != 0) begin : g_bad_data_width
    $fatal(1, "sram_dp_be: DATA_WIDTH must be a multiple of 8");
  end
  if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
    $fatal(1, "sram_dp_be: READ_LATENCY must be 1 or 2");
  end

  logic                  clr_we;
  logic [ADDR_WIDTH-1:0] clr_addr;
  logic                  ready_int;

  sram_init_ctrl #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_init (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_we  (clr_we),
    .clr_addr(clr_addr),
    .ready   (ready_int)
  );

  assign ready = ready_int;

  logic                  wr_acc;
  logic                  rd_acc;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rd_word_d;
  logic [DATA_WIDTH-1:0] s1_data_q;
  logic                  s1_valid_q;

  assign wr_acc = ready_int & wr_en;
  assign rd_acc = ready_int & rd_en;

  // Storage has no reset; the init sequencer owns the write port until ready.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem_q[clr_addr] <= '0;
    end else if (wr_acc) begin
      for (int i = 0; i < NB; i++) begin
        if (wr_be[i]) begin
          mem_q[wr_addr][BYTE_W*i +: BYTE_W] <= wr_data[BYTE_W*i +: BYTE_W];
        end
      end
    end
  end

  always_comb begin
    rd_word_d = mem_q[rd_addr];
    if (RDW_MODE == WRITE_FIRST && wr_acc && (wr_addr == rd_addr)) begin
      for (int i = 0; i < NB; i++) begin
        if (wr_be[i]) begin
          rd_word_d[BYTE_W*i +: BYTE_W] = wr_data[BYTE_W*i +: BYTE_W];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
    end else begin
      s1_valid_q <= rd_acc;
      if (rd_acc) begin
        s1_data_q <= rd_word_d;
      end
    end
  end

  if (READ_LATENCY == 2) begin : g_lat2
    logic [DATA_WIDTH-1:0] s2_data_q;
    logic                  s2_valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s2_valid_q <= 1'b0;
        s2_data_q  <= '0;
      end else begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          s2_data_q <= s1_data_q;
        end
      end
    end

    assign rd_data  = s2_data_q;
    assign rd_valid = s2_valid_q;
  end else begin : g_lat1
    assign rd_data  = s1_data_q;
    assign rd_valid = s1_valid_q;
  end

endmodule

`default_nettype wire
